// File: rtl/fp16_pkg.sv
// Shared binary16 field layout, constants and controller state encoding
// for the sequential half-precision multiplier.
package fp16_pkg;

   localparam int unsigned EXP_W     = 5;
   localparam int unsigned FRAC_W    = 10;
   localparam int unsigned MANT_W    = FRAC_W + 1;
   localparam int unsigned BIAS      = 15;
   localparam int unsigned MUL_STEPS = MANT_W;
   localparam int unsigned CNT_W     = 4;

   localparam logic [15:0]      QNAN    = 16'h7E00;
   localparam logic [14:0]      INF     = 15'h7C00;
   localparam logic [EXP_W-1:0] EXP_MAX = '1;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [FRAC_W-1:0] frac;
   } fp16_t;

   typedef enum logic [2:0] {
      IDLE,
      EXP_ADD,
      EXP_BIAS,
      MUL,
      NORM,
      RANGE,
      DONE
   } ctrl_state_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational operand classifier: zero (denormals flushed), infinity, NaN.
module fp16_classify
   import fp16_pkg::*;
(
   input  fp16_t op,
   output logic  is_zero,
   output logic  is_inf,
   output logic  is_nan
);

   logic unused_sign;
   assign unused_sign = op.sign;

   always_comb begin
      is_zero = (op.exp == '0);
      is_inf  = (op.exp == EXP_MAX) && (op.frac == '0);
      is_nan  = (op.exp == EXP_MAX) && (op.frac != '0);
   end

endmodule

// File: rtl/fpm_seq_ctrl.sv
// Sequential binary16 multiplier controller: time-shares one external add/sub
// ALU for exponent add, bias removal, shift-add mantissa multiply and range checks.
module fpm_seq_ctrl
   import fp16_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_in,
   input  logic [15:0]      a_in,
   input  logic [15:0]      b_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [15:0]      result_out,
   output logic [WIDTH-1:0] alu_A_out,
   output logic [WIDTH-1:0] alu_B_out,
   output logic             alu_op_out,
   input  logic [WIDTH-1:0] alu_result_in,
   input  logic             alu_Z_in,
   input  logic             alu_N_in,
   input  logic             alu_C_in
);

   ctrl_state_t state;

   logic                sign;
   logic [EXP_W-1:0]    ea;
   logic [EXP_W-1:0]    eb;
   logic [MANT_W-1:0]   mcand;
   logic [MANT_W-1:0]   q;
   logic [MANT_W-1:0]   acc;
   logic [WIDTH-1:0]    esum;
   logic [WIDTH-1:0]    e;
   logic [WIDTH-1:0]    ef;
   logic [FRAC_W-1:0]   frac;
   logic [CNT_W-1:0]    cnt;

   logic unused_carry;
   assign unused_carry = alu_C_in;

   fp16_t op_a;
   fp16_t op_b;
   logic  a_zero, a_inf, a_nan;
   logic  b_zero, b_inf, b_nan;

   assign op_a = a_in;
   assign op_b = b_in;

   fp16_classify u_cls_a (
      .op      (op_a),
      .is_zero (a_zero),
      .is_inf  (a_inf),
      .is_nan  (a_nan)
   );

   fp16_classify u_cls_b (
      .op      (op_b),
      .is_zero (b_zero),
      .is_inf  (b_inf),
      .is_nan  (b_nan)
   );

   // Special-operand resolution in priority order: NaN / inf*zero, inf, zero
   logic        sp_sign;
   logic        special;
   logic [15:0] sp_result;

   always_comb begin
      sp_sign   = op_a.sign ^ op_b.sign;
      special   = 1'b1;
      sp_result = {sp_sign, 15'h0000};
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         sp_result = QNAN;
      end else if (a_inf || b_inf) begin
         sp_result = {sp_sign, INF};
      end else if (a_zero || b_zero) begin
         sp_result = {sp_sign, 15'h0000};
      end else begin
         special = 1'b0;
      end
   end

   // Multiply step and normalisation views of the {acc,q} product register
   logic [MANT_W:0]     mul_sum;
   logic [2*MANT_W-1:0] prod;
   logic                p_hi;
   logic [FRAC_W-1:0]   frac_n;

   always_comb begin
      mul_sum = q[0] ? alu_result_in[MANT_W:0] : {1'b0, acc};
      prod    = {acc, q};
      p_hi    = prod[2*MANT_W-1];
      frac_n  = p_hi ? prod[2*MANT_W-2 -: FRAC_W] : prod[2*MANT_W-3 -: FRAC_W];
   end

   // ALU operand drive, purely a function of the current state
   always_comb begin
      alu_A_out  = '0;
      alu_B_out  = '0;
      alu_op_out = 1'b0;
      case (state)
         EXP_ADD: begin
            alu_A_out = WIDTH'(ea);
            alu_B_out = WIDTH'(eb);
         end
         EXP_BIAS: begin
            alu_A_out  = esum;
            alu_B_out  = WIDTH'(BIAS);
            alu_op_out = 1'b1;
         end
         MUL: begin
            if (q[0]) begin
               alu_A_out = WIDTH'(acc);
               alu_B_out = WIDTH'(mcand);
            end
         end
         NORM: begin
            alu_A_out = e;
            alu_B_out = WIDTH'(p_hi);
         end
         RANGE: begin
            alu_A_out  = ef;
            alu_B_out  = WIDTH'(EXP_MAX);
            alu_op_out = 1'b1;
         end
         default: begin
            alu_A_out  = '0;
            alu_B_out  = '0;
            alu_op_out = 1'b0;
         end
      endcase
   end

   // Controller state, datapath registers and registered outputs
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state      <= IDLE;
         busy_out   <= 1'b0;
         done_out   <= 1'b0;
         result_out <= '0;
         sign       <= 1'b0;
         ea         <= '0;
         eb         <= '0;
         mcand      <= '0;
         q          <= '0;
         acc        <= '0;
         esum       <= '0;
         e          <= '0;
         ef         <= '0;
         frac       <= '0;
         cnt        <= '0;
      end else begin
         done_out <= 1'b0;
         case (state)
            IDLE: begin
               if (start_in) begin
                  sign     <= sp_sign;
                  ea       <= op_a.exp;
                  eb       <= op_b.exp;
                  mcand    <= {1'b1, op_a.frac};
                  q        <= {1'b1, op_b.frac};
                  acc      <= '0;
                  cnt      <= '0;
                  busy_out <= 1'b1;
                  if (special) begin
                     result_out <= sp_result;
                     done_out   <= 1'b1;
                     state      <= DONE;
                  end else begin
                     state <= EXP_ADD;
                  end
               end
            end
            EXP_ADD: begin
               esum  <= alu_result_in;
               state <= EXP_BIAS;
            end
            EXP_BIAS: begin
               e     <= alu_result_in;
               state <= MUL;
            end
            MUL: begin
               acc <= mul_sum[MANT_W:1];
               q   <= {mul_sum[0], q[MANT_W-1:1]};
               if (cnt == CNT_W'(MUL_STEPS - 1)) begin
                  cnt   <= '0;
                  state <= NORM;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            NORM: begin
               ef   <= alu_result_in;
               frac <= frac_n;
               if (alu_N_in || alu_Z_in) begin
                  result_out <= {sign, 15'h0000};
                  done_out   <= 1'b1;
                  state      <= DONE;
               end else begin
                  state <= RANGE;
               end
            end
            RANGE: begin
               if (!alu_N_in) begin
                  result_out <= {sign, INF};
               end else begin
                  result_out <= {sign, ef[EXP_W-1:0], frac};
               end
               done_out <= 1'b1;
               state    <= DONE;
            end
            DONE: begin
               busy_out <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               busy_out <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fpm_seq_ctrl.sv
// Bench for fpm_seq_ctrl: external ALU model, cycle-level reference of the
// observable behaviour, and directed vectors with hand-computed results.
module tb_fpm_seq_ctrl;

   localparam int unsigned WIDTH = 16;

   logic             clk_in;
   logic             rst_in;
   logic             start_in;
   logic [15:0]      a_in;
   logic [15:0]      b_in;
   logic             busy_out;
   logic             done_out;
   logic [15:0]      result_out;
   logic [WIDTH-1:0] alu_A_out;
   logic [WIDTH-1:0] alu_B_out;
   logic             alu_op_out;
   logic [WIDTH-1:0] alu_result_in;
   logic             alu_Z_in;
   logic             alu_N_in;
   logic             alu_C_in;

   int errors = 0;
   int checks = 0;

   fpm_seq_ctrl #(.WIDTH(WIDTH)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_in      (start_in),
      .a_in          (a_in),
      .b_in          (b_in),
      .busy_out      (busy_out),
      .done_out      (done_out),
      .result_out    (result_out),
      .alu_A_out     (alu_A_out),
      .alu_B_out     (alu_B_out),
      .alu_op_out    (alu_op_out),
      .alu_result_in (alu_result_in),
      .alu_Z_in      (alu_Z_in),
      .alu_N_in      (alu_N_in),
      .alu_C_in      (alu_C_in)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   // Shared external add/sub ALU
   logic [WIDTH:0] alu_full;
   always_comb begin
      if (alu_op_out) alu_full = {1'b0, alu_A_out} - {1'b0, alu_B_out};
      else            alu_full = {1'b0, alu_A_out} + {1'b0, alu_B_out};
      alu_result_in = alu_full[WIDTH-1:0];
      alu_Z_in      = (alu_full[WIDTH-1:0] == '0);
      alu_N_in      = alu_full[WIDTH-1];
      alu_C_in      = alu_full[WIDTH];
   end

   // Reference product: returns {latency[4:0], result[15:0]}
   function automatic logic [20:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
      int ea, eb, e, p, fr;
      bit s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      s      = a[15] ^ b[15];
      ea     = int'(a[14:10]);
      eb     = int'(b[14:10]);
      a_nan  = (ea == 31) && (a[9:0] != 0);
      b_nan  = (eb == 31) && (b[9:0] != 0);
      a_inf  = (ea == 31) && (a[9:0] == 0);
      b_inf  = (eb == 31) && (b[9:0] == 0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return {5'd1, 16'h7E00};
      if (a_inf || b_inf) return {5'd1, s, 15'h7C00};
      if (a_zero || b_zero) return {5'd1, s, 15'h0000};
      p = (1024 + int'(a[9:0])) * (1024 + int'(b[9:0]));
      e = ea + eb - 15;
      if (p >= (1 << 21)) begin
         e  = e + 1;
         fr = (p >> 11) % 1024;
      end else begin
         fr = (p >> 10) % 1024;
      end
      if (e <= 0) return {5'd15, s, 15'h0000};
      if (e >= 31) return {5'd16, s, 15'h7C00};
      return {5'd16, s, 5'(e), 10'(fr)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Observable-behaviour model: cycle count since accept, done at the target cycle
   logic [20:0] m_ref;
   int          m_cnt;
   int          m_target;
   logic [15:0] m_pend;
   logic [15:0] m_result;

   always_comb m_ref = ref_mul(a_in, b_in);

   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         m_cnt    <= 0;
         m_target <= 0;
         m_pend   <= '0;
         m_result <= '0;
      end else if (m_cnt == 0) begin
         if (start_in) begin
            m_cnt    <= 1;
            m_target <= int'(m_ref[20:16]);
            m_pend   <= m_ref[15:0];
            if (m_ref[20:16] == 5'd1) m_result <= m_ref[15:0];
         end
      end else if (m_cnt == m_target) begin
         m_cnt <= 0;
      end else begin
         m_cnt <= m_cnt + 1;
         if (m_cnt + 1 == m_target) m_result <= m_pend;
      end
   end

   always @(negedge clk_in) begin
      if (!rst_in) begin
         check("cyc_busy",   32'(busy_out),   32'(m_cnt != 0));
         check("cyc_done",   32'(done_out),   32'((m_cnt != 0) && (m_cnt == m_target)));
         check("cyc_result", 32'(result_out), 32'(m_result));
      end
   end

   // Waits (bounded) for done; returns the cycle number it appeared in, 0 on timeout
   task automatic wait_done(output int lat);
      int  n;
      bit  seen;
      n    = 1;
      seen = 1'b0;
      while (n < 40 && !seen) begin
         if (done_out) seen = 1'b1;
         else begin
            @(negedge clk_in);
            n++;
         end
      end
      lat = seen ? n : 0;
   endtask

   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_res, input int exp_lat);
      int lat;
      @(negedge clk_in);
      a_in     = a;
      b_in     = b;
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      a_in     = 16'h5555;
      b_in     = 16'hAAAA;
      wait_done(lat);
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
      check({name, "_res"}, 32'(result_out), 32'(exp_res));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      rst_in   = 1'b1;
      start_in = 1'b0;
      a_in     = '0;
      b_in     = '0;
      repeat (2) @(negedge clk_in);
      check("rst_busy",   32'(busy_out),   32'd0);
      check("rst_done",   32'(done_out),   32'd0);
      check("rst_result", 32'(result_out), 32'd0);
      rst_in = 1'b0;

      run_op("one_x_one",   16'h3C00, 16'h3C00, 16'h3C00, 16);
      run_op("p21_path",    16'h3E00, 16'h3E00, 16'h4080, 16);
      run_op("neg2_x_3",    16'hC000, 16'h4200, 16'hC600, 16);
      run_op("overflow",    16'h7BFF, 16'h7BFF, 16'h7C00, 16);
      run_op("underflow",   16'h0400, 16'h0400, 16'h0000, 15);
      run_op("zero_x_inf",  16'h0000, 16'h7C00, 16'h7E00, 1);
      run_op("nzero_x_one", 16'h8000, 16'h3C00, 16'h8000, 1);
      run_op("ninf_x_two",  16'hFC00, 16'h4000, 16'hFC00, 1);
      run_op("nan_x_one",   16'h7E01, 16'h3C00, 16'h7E00, 1);
      run_op("denorm",      16'h3C00, 16'h0001, 16'h0000, 1);

      // start held high with new operands while busy: ignored until back in IDLE
      @(negedge clk_in);
      a_in     = 16'h3C00;
      b_in     = 16'h3C00;
      start_in = 1'b1;
      @(negedge clk_in);
      a_in = 16'h4000;
      b_in = 16'h4000;
      wait_done(lat);
      check("held_first_lat", 32'(lat), 32'd16);
      check("held_first_res", 32'(result_out), 32'h3C00);
      @(negedge clk_in);
      check("held_idle_busy", 32'(busy_out), 32'd0);
      @(negedge clk_in);
      start_in = 1'b0;
      wait_done(lat);
      check("held_second_lat", 32'(lat), 32'd16);
      check("held_second_res", 32'(result_out), 32'h4400);

      // asynchronous reset in the middle of the multiply loop
      @(negedge clk_in);
      a_in     = 16'h3C00;
      b_in     = 16'h3E00;
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      repeat (5) @(negedge clk_in);
      #2 rst_in = 1'b1;
      #1;
      check("arst_busy",   32'(busy_out),   32'd0);
      check("arst_done",   32'(done_out),   32'd0);
      check("arst_result", 32'(result_out), 32'd0);
      @(negedge clk_in);
      rst_in = 1'b0;
      repeat (20) begin
         @(negedge clk_in);
         check("arst_no_done", 32'(done_out), 32'd0);
      end
      run_op("after_rst", 16'h3C00, 16'h4000, 16'h4000, 16);

      repeat (2) @(negedge clk_in);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
